spi_mult_master: RTL and testbench

SPI_MULT_MASTER -- requirements
Module: spi_mult_master

---
 rtl/spi_mult_master.sv | 193 +++++++++++++++++++
 tb/tb_spi_mult_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_master.sv
// -----------------------------------------------------------------------------
// spi_mult_master
//
// SPI master that sends two 4-bit operands to an external multiplier
// peripheral and reads back the 8-bit product.
//
// A transaction has these phases:
//   SETUP : chip select asserted, first data bit presented, sclk low.
//   WRITE : 8 SCLK periods. The shift word {b,a} is sent MSB first.
//   GAP   : GAP_BITS dummy periods while the peripheral multiplies.
//   READ  : 8 SCLK periods. The product is received MSB first.
//   HOLD  : sclk stays low, with cs still asserted, for one half-period.
//   DONE  : one cycle. cs is released, done pulses and result updates.
//
// Handshake: start is a request that is honoured only in IDLE. busy goes high
// on the cycle after the request is taken and stays high until the DONE
// cycle. A request seen while busy is high, or during DONE, is dropped.
//
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   start, a, b  transaction request and operands (captured on acceptance)
//   busy, done   transaction in flight / one-cycle completion pulse
//   result       last product read back (held between transactions)
//   cs, sclk,    SPI pins: active-low select, serial clock (idles low),
//   mosi, miso   serial data out, serial data in
//   state_dbg    current FSM state, for observation only
// -----------------------------------------------------------------------------
module spi_mult_master #(
    parameter int HALF_PERIOD = 8,
    parameter int GAP_BITS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    logic [2:0] state;
    logic [7:0] div;       // clk count within the current half-period
    logic [3:0] bit_cnt;   // SCLK period index within the current phase
    logic [7:0] tx;        // outgoing word; tx[7] is the bit on mosi
    logic [7:0] rx;        // incoming product, shifted in MSB first
    logic       div_wrap;
    logic       phase_last;
    logic       in_txn;

    assign div_wrap = (div == DIV_LAST);

    always_comb begin
        phase_last = 1'b0;
        if (state == S_GAP) begin
            phase_last = (bit_cnt == GAP_LAST);
        end else begin
            phase_last = (bit_cnt == 4'd7);
        end
    end

    always_comb begin
        in_txn = 1'b0;
        case (state)
            S_SETUP, S_WRITE, S_GAP, S_READ, S_HOLD: in_txn = 1'b1;
            default:                                 in_txn = 1'b0;
        endcase
    end

    assign cs        = ~in_txn;
    assign busy      = in_txn;
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            div     <= 8'd0;
            bit_cnt <= 4'd0;
            tx      <= 8'h00;
            rx      <= 8'h00;
            result  <= 8'h00;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div     <= 8'd0;
                    bit_cnt <= 4'd0;
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    if (start) begin
                        tx    <= {b, a};
                        rx    <= 8'h00;
                        // First bit is presented for the whole SETUP phase.
                        mosi  <= b[3];
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (div_wrap) begin
                        div     <= 8'd0;
                        bit_cnt <= 4'd0;
                        sclk    <= 1'b1;
                        state   <= S_WRITE;
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                S_WRITE, S_GAP, S_READ: begin
                    if (!div_wrap) begin
                        div <= div + 8'd1;
                    end else begin
                        div <= 8'd0;
                        if (sclk) begin
                            // End of the high half: falling edge. Data out
                            // moves here so it is settled well before the
                            // next rising edge; data in is sampled here.
                            sclk <= 1'b0;
                            if (state == S_WRITE) begin
                                tx   <= {tx[6:0], 1'b0};
                                mosi <= (bit_cnt == 4'd7) ? 1'b0 : tx[6];
                            end
                            if (state == S_READ) begin
                                rx <= {rx[6:0], miso};
                            end
                        end else begin
                            // End of the low half closes one SCLK period.
                            if (phase_last) begin
                                bit_cnt <= 4'd0;
                                case (state)
                                    S_WRITE: begin
                                        state <= S_GAP;
                                        sclk  <= 1'b1;
                                    end
                                    S_GAP: begin
                                        state <= S_READ;
                                        sclk  <= 1'b1;
                                    end
                                    default: begin
                                        // Last READ period: no further edge.
                                        state <= S_HOLD;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sclk    <= 1'b1;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (div_wrap) begin
                        div    <= 8'd0;
                        // Loaded on entry to DONE so result is valid with done.
                        result <= rx;
                        state  <= S_DONE;
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mult_master.sv
// -----------------------------------------------------------------------------
// tb_spi_mult_master
//
// Two instances run side by side: instance 0 uses the default parameters
// (HALF_PERIOD=8, GAP_BITS=4) and instance 1 uses HALF_PERIOD=4, GAP_BITS=1.
// Each instance has its own stimulus, peripheral model and reference model.
// The reference model tracks each transaction as an offset from the accepting
// edge and derives the expected pins from the timeline arithmetic.
// -----------------------------------------------------------------------------
module tb_spi_mult_master;

    // ---------------- clock ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus (written only by the main block) ----------
    logic       rst_v   [2];
    logic       start_v [2];
    logic [3:0] a_v     [2];
    logic [3:0] b_v     [2];
    bit         chk_on = 1'b0;

    // ---------------- peripheral drive (written only by the negedge block)
    logic miso_v [2] = '{1'b0, 1'b0};

    // ---------------- DUT outputs ----------------
    logic       o0_busy, o0_done, o0_cs, o0_sclk, o0_mosi;
    logic [7:0] o0_result;
    logic [2:0] o0_state;
    logic       o1_busy, o1_done, o1_cs, o1_sclk, o1_mosi;
    logic [7:0] o1_result;
    logic [2:0] o1_state;

    spi_mult_master #(.HALF_PERIOD(8), .GAP_BITS(4)) dut0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(o0_busy), .done(o0_done), .result(o0_result), .cs(o0_cs),
        .sclk(o0_sclk), .mosi(o0_mosi), .miso(miso_v[0]), .state_dbg(o0_state)
    );

    spi_mult_master #(.HALF_PERIOD(4), .GAP_BITS(1)) dut1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(o1_busy), .done(o1_done), .result(o1_result), .cs(o1_cs),
        .sclk(o1_sclk), .mosi(o1_mosi), .miso(miso_v[1]), .state_dbg(o1_state)
    );

    // ---------------- bookkeeping ----------------
    int n_chk   = 0;
    int n_fail  = 0;
    int n_print = 0;

    function automatic int hp(int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic int gp(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Offset (in cycles after the accepting edge) of the done cycle.
    function automatic int lat(int i);
        return 2 * hp(i) * (17 + gp(i)) + 1;
    endfunction

    // Expected {cs, sclk, mosi} at offset kk of an active transaction (kk < lat).
    function automatic logic [2:0] exp_lines(int h, int g, int kk, logic [7:0] w);
        int   off;
        int   p;
        logic hi;
        logic bt;
        if (kk <= h) return {1'b0, 1'b0, w[7]};
        if (kk <= h + 2 * h * (16 + g)) begin
            off = kk - h - 1;
            p   = off / (2 * h);
            hi  = ((off % (2 * h)) < h);
            bt  = 1'b0;
            if (p < 8) begin
                if (hi) bt = w[7 - p];
                else if (p < 7) bt = w[6 - p];
            end
            return {1'b0, hi, bt};
        end
        return 3'b000;
    endfunction

    task automatic report(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model (posedge) ----------------
    bit         m_act    [2] = '{1'b0, 1'b0};
    int         m_k      [2] = '{0, 0};
    logic [7:0] m_w      [2] = '{8'h00, 8'h00};
    logic [7:0] m_r      [2] = '{8'h00, 8'h00};
    logic [7:0] m_res    [2] = '{8'h00, 8'h00};
    int         m_tick   [2] = '{0, 0};
    int         acc_last [2] = '{0, 0};
    int         acc_prev [2] = '{0, 0};
    int         acc_cnt  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_tick[i]++;
            if (rst_v[i]) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                m_res[i] = 8'h00;
            end else if (m_act[i]) begin
                if (m_k[i] == lat(i)) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_k[i]++;
                    if (m_k[i] == lat(i)) m_res[i] = m_r[i];
                end
            end else if (start_v[i]) begin
                m_act[i]    = 1'b1;
                m_k[i]      = 1;
                m_w[i]      = {b_v[i], a_v[i]};
                m_r[i]      = {4'b0, a_v[i]} * {4'b0, b_v[i]};
                acc_prev[i] = acc_last[i];
                acc_last[i] = m_tick[i];
                acc_cnt[i]++;
            end
        end
    end

    // ---------------- peripheral + per-cycle compare (negedge) ----------
    logic       o_cs [2], o_sclk [2], o_mosi [2], o_busy [2], o_done [2];
    logic [7:0] o_res [2];
    bit         prev_cs     [2] = '{1'b1, 1'b1};
    bit         prev_sclk   [2] = '{1'b0, 1'b0};
    bit         first_rise  [2] = '{1'b1, 1'b1};
    int         run_len     [2] = '{0, 0};
    int         per_n       [2] = '{0, 0};
    logic [7:0] per_rx      [2] = '{8'h00, 8'h00};
    logic [7:0] per_r       [2] = '{8'h00, 8'h00};
    int         done_seen_k [2] = '{-1, -1};
    int         done_cnt    [2] = '{0, 0};
    int         busy_cnt    [2] = '{0, 0};

    always @(negedge clk) begin
        logic [2:0] e;
        logic       eb;
        logic       ed;
        o_cs[0] = o0_cs;  o_sclk[0] = o0_sclk;  o_mosi[0] = o0_mosi;
        o_busy[0] = o0_busy;  o_done[0] = o0_done;  o_res[0] = o0_result;
        o_cs[1] = o1_cs;  o_sclk[1] = o1_sclk;  o_mosi[1] = o1_mosi;
        o_busy[1] = o1_busy;  o_done[1] = o1_done;  o_res[1] = o1_result;
        for (int i = 0; i < 2; i++) begin
            // Peripheral: latches mosi on sclk rise, drives the product on miso.
            if (!o_cs[i] && prev_cs[i]) begin
                per_n[i]      = 0;
                first_rise[i] = 1'b1;
                run_len[i]    = 0;
            end
            if (!o_cs[i]) begin
                if (o_sclk[i] != prev_sclk[i]) begin
                    if (!o_sclk[i]) begin
                        if (chk_on) report("sclk_high_width", run_len[i], hp(i));
                    end else begin
                        if (chk_on && !first_rise[i]) report("sclk_low_width", run_len[i], hp(i));
                        first_rise[i] = 1'b0;
                        if (per_n[i] < 8) per_rx[i] = {per_rx[i][6:0], o_mosi[i]};
                        if (per_n[i] == 7) per_r[i] = {4'b0, per_rx[i][7:4]} * {4'b0, per_rx[i][3:0]};
                        if (per_n[i] >= 8 + gp(i) && per_n[i] < 16 + gp(i))
                            miso_v[i] = per_r[i][7 - (per_n[i] - 8 - gp(i))];
                        per_n[i]++;
                    end
                    run_len[i] = 1;
                end else begin
                    run_len[i]++;
                end
            end
            prev_cs[i]   = o_cs[i];
            prev_sclk[i] = o_sclk[i];

            if (chk_on) begin
                eb = m_act[i] && (m_k[i] < lat(i));
                ed = m_act[i] && (m_k[i] == lat(i));
                e  = eb ? exp_lines(hp(i), gp(i), m_k[i], m_w[i]) : 3'b100;
                n_chk++;
                if ({o_cs[i], o_sclk[i], o_mosi[i], o_busy[i], o_done[i], o_res[i]} !==
                    {e, eb, ed, m_res[i]}) begin
                    n_fail++;
                    if (n_print < 30) begin
                        n_print++;
                        $display("FAIL cycle_compare inst%0d k=%0d: got cs/sclk/mosi/busy/done=%b%b%b%b%b result=%h, expected %b%b%b result=%h",
                                 i, m_k[i], o_cs[i], o_sclk[i], o_mosi[i], o_busy[i], o_done[i],
                                 o_res[i], e, eb, ed, m_res[i]);
                    end
                end
                if (ed) begin
                    report("sclk_rise_count", per_n[i], 16 + gp(i));
                    report("received_word", per_rx[i], m_w[i]);
                end
            end
            if (m_act[i] && m_k[i] == 1) busy_cnt[i] = 0;
            if (o_busy[i]) busy_cnt[i]++;
            if (o_done[i]) begin
                done_cnt[i]++;
                done_seen_k[i] = m_act[i] ? m_k[i] : -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(int i, logic [3:0] aa, logic [3:0] bb);
        a_v[i]     = aa;
        b_v[i]     = bb;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    // Runs until the model is idle; optionally scrambles operands and
    // pulses start while the transaction is in flight.
    task automatic wait_idle(int i, bit noise);
        int n;
        n = 0;
        while (m_act[i] && n < 2000) begin
            if (noise) begin
                a_v[i]     = 4'($urandom_range(0, 15));
                b_v[i]     = 4'($urandom_range(0, 15));
                start_v[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
            n++;
        end
        start_v[i] = 1'b0;
        if (m_act[i]) report("idle_timeout", 1, 0);
    endtask

    task automatic run_txn(int i, logic [3:0] aa, logic [3:0] bb, bit noise);
        start_txn(i, aa, bb);
        wait_idle(i, noise);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int kr;
        int n;
        for (int i = 0; i < 2; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
            a_v[i]     = 4'h0;
            b_v[i]     = 4'h0;
        end
        tick();
        tick();
        chk_on = 1'b1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        report("reset_result", o0_result, 8'h00);
        report("reset_cs", o0_cs, 1'b1);
        tick();

        // Abort at offset 100.
        start_txn(0, 4'h6, 4'h6);
        n = 0;
        while (m_k[0] != 100 && n < 500) begin tick(); n++; end
        report("abort_reach_k100", m_k[0], 100);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        report("abort_cs", o0_cs, 1'b1);
        report("abort_sclk", o0_sclk, 1'b0);
        repeat (400) tick();
        report("abort_no_done", done_cnt[0], 0);
        report("abort_result", o0_result, 8'h00);

        // a=3, b=5.
        run_txn(0, 4'h3, 4'h5, 1'b0);
        report("mosi_word_35", per_rx[0], 8'h53);
        report("result_35", o0_result, 8'h0F);
        report("done_latency_337", done_seen_k[0], 337);
        report("sclk_rises_20", per_n[0], 20);

        // a=F, b=F.
        run_txn(0, 4'hF, 4'hF, 1'b0);
        report("result_ff", o0_result, 8'hE1);
        report("busy_cycles_336", busy_cnt[0], 336);

        // Operands change right after acceptance.
        start_txn(0, 4'h2, 4'h7);
        a_v[0] = 4'h9;
        b_v[0] = 4'hC;
        wait_idle(0, 1'b0);
        report("captured_word", per_rx[0], 8'h72);
        report("captured_result", o0_result, 8'h0E);

        // Reset and start together: reset wins.
        c0 = acc_cnt[0];
        rst_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        tick();
        rst_v[0]   = 1'b0;
        start_v[0] = 1'b0;
        report("reset_wins_busy", o0_busy, 1'b0);
        report("reset_wins_accepts", acc_cnt[0] - c0, 0);
        tick();
        report("reset_wins_busy_later", o0_busy, 1'b0);

        // Start held high for 400 cycles.
        c0 = acc_cnt[0];
        start_v[0] = 1'b1;
        repeat (400) begin
            a_v[0] = 4'($urandom_range(0, 15));
            b_v[0] = 4'($urandom_range(0, 15));
            tick();
        end
        start_v[0] = 1'b0;
        report("spam_accepts", acc_cnt[0] - c0, 2);
        report("spam_second_accept", acc_last[0] - acc_prev[0], 338);
        wait_idle(0, 1'b0);

        // Short-timing instance.
        run_txn(1, 4'hA, 4'h6, 1'b0);
        report("fast_result", o1_result, 8'h3C);
        report("fast_done_145", done_seen_k[1], 145);
        for (int t = 0; t < 4; t++) begin
            run_txn(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Randomized traffic on the default instance.
        for (int t = 0; t < 14; t++) begin
            repeat ($urandom_range(0, 3)) begin
                a_v[0] = 4'($urandom_range(0, 15));
                b_v[0] = 4'($urandom_range(0, 15));
                tick();
            end
            if ($urandom_range(0, 5) == 0) begin
                kr = $urandom_range(1, lat(0));
                start_txn(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                n = 0;
                while (m_act[0] && m_k[0] != kr && n < 2000) begin tick(); n++; end
                rst_v[0] = 1'b1;
                tick();
                rst_v[0] = 1'b0;
                report("rand_abort_idle", o0_busy, 1'b0);
            end else begin
                run_txn(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            end
        end
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
